// File: rtl/pe_row_seq_pkg.sv
// Shared constants for the PE row sequencer: default widths, tap count and
// FSM state encoding.
package pe_row_seq_pkg;

  localparam int IFMAP_WID_D  = 8;
  localparam int WEIGHT_WID_D = 8;
  localparam int PSUM_WID_D   = 20;
  localparam int LEN_WID_D    = 8;

  // Taps in the PE sliding window (weights per row, pixels per window)
  localparam int TAP_CNT = 3;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_LOAD_W = 3'd2,
    S_LOAD_I = 3'd3,
    S_FLUSH  = 3'd4,
    S_DONE   = 3'd5
  } state_t;

endpackage

// File: rtl/pe_row_out_slot.sv
// One-entry output register for PE partial sums with a valid/ready handshake.
// Optional build macro PE_ROW_SEQ_RELU_EN clamps negative captures to zero.
module pe_row_out_slot
  import pe_row_seq_pkg::*;
#(
  parameter int PSUM_WID = PSUM_WID_D
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_load,
  input  logic                       i_last,
  input  logic signed [PSUM_WID-1:0] i_psum,
  input  logic                       i_ready,
  output logic                       o_valid,
  output logic                       o_last,
  output logic signed [PSUM_WID-1:0] o_psum
);

  logic signed [PSUM_WID-1:0] w_psum_cap;
  logic signed [PSUM_WID-1:0] r_psum;
  logic                       r_last;
  logic                       r_valid;

`ifdef PE_ROW_SEQ_RELU_EN
  assign w_psum_cap = i_psum[PSUM_WID-1] ? '0 : i_psum;
`else
  assign w_psum_cap = i_psum;
`endif

  // Load wins over drain so a capture in the handshake cycle keeps the slot full;
  // data holds while valid and not accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_psum  <= '0;
      r_last  <= 1'b0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_psum  <= w_psum_cap;
      r_last  <= i_last;
      r_valid <= 1'b1;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_last  = r_last;
  assign o_psum  = r_psum;

endmodule

// File: rtl/pe_row_seq.sv
// Row sequencer: clears one PE, loads its three weights, streams one ifmap row
// and captures each full-window partial sum into pe_row_out_slot.
// Build macro PE_ROW_SEQ_RELU_EN (in pe_row_out_slot) enables the ReLU clamp.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | waiting for start; row length latched on start
// S_CLEAR  | one-cycle PE FIFO clear; short rows skip straight to S_DONE
// S_LOAD_W | accept TAP_CNT weights, one per cycle
// S_LOAD_I | stream pixels; capture psum the cycle after each full window
// S_FLUSH  | last pixel written; wait for final capture to be accepted
// S_DONE   | one-cycle done pulse
module pe_row_seq
  import pe_row_seq_pkg::*;
#(
  parameter int IFMAP_WID  = IFMAP_WID_D,
  parameter int WEIGHT_WID = WEIGHT_WID_D,
  parameter int PSUM_WID   = PSUM_WID_D,
  parameter int LEN_WID    = LEN_WID_D
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [LEN_WID-1:0]           cfg_row_len,
  output logic                         busy,
  output logic                         done,
  input  logic                         w_valid,
  output logic                         w_ready,
  input  logic signed [WEIGHT_WID-1:0] w_data,
  input  logic                         i_valid,
  output logic                         i_ready,
  input  logic signed [IFMAP_WID-1:0]  i_data,
  output logic signed [IFMAP_WID-1:0]  pe_ifmap,
  output logic                         pe_ifmap_wen,
  output logic signed [WEIGHT_WID-1:0] pe_weight,
  output logic                         pe_weight_wen,
  output logic                         pe_reg_clear,
  input  logic signed [PSUM_WID-1:0]   pe_psum,
  output logic                         o_valid,
  input  logic                         o_ready,
  output logic signed [PSUM_WID-1:0]   o_psum,
  output logic                         o_last
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [LEN_WID-1:0] r_row_len;
  logic [LEN_WID-1:0] r_pix_cnt;
  logic [1:0]         r_w_cnt;
  logic               r_cap_pend;

  logic [LEN_WID-1:0] w_pix_inc;
  logic               w_row_short;
  logic               w_window_full;
  logic               w_last_pix;
  logic               w_cap_last;
  logic               w_i_rdy;
  logic               w_w_hs;
  logic               w_i_hs;

  assign w_pix_inc     = r_pix_cnt + 1'b1;
  assign w_row_short   = r_row_len < LEN_WID'(TAP_CNT);
  assign w_window_full = w_pix_inc >= LEN_WID'(TAP_CNT);
  assign w_last_pix    = w_pix_inc == r_row_len;
  assign w_cap_last    = r_pix_cnt == r_row_len;

  // A pixel may enter only when no capture is pending and the slot will have room
  assign w_i_rdy = (r_state == S_LOAD_I) && !r_cap_pend && (!o_valid || o_ready);

  // Next-state decode and PE load-port drive; wen strobes only on handshakes
  always_comb begin
    w_state_nxt   = r_state;
    busy          = (r_state != S_IDLE);
    done          = 1'b0;
    w_ready       = 1'b0;
    i_ready       = 1'b0;
    pe_ifmap      = '0;
    pe_ifmap_wen  = 1'b0;
    pe_weight     = '0;
    pe_weight_wen = 1'b0;
    pe_reg_clear  = 1'b0;
    w_w_hs        = 1'b0;
    w_i_hs        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_CLEAR;
      end
      S_CLEAR: begin
        pe_reg_clear = 1'b1;
        w_state_nxt  = w_row_short ? S_DONE : S_LOAD_W;
      end
      S_LOAD_W: begin
        w_ready = 1'b1;
        if (w_valid) begin
          w_w_hs        = 1'b1;
          pe_weight     = w_data;
          pe_weight_wen = 1'b1;
          if (r_w_cnt == 2'(TAP_CNT - 1)) w_state_nxt = S_LOAD_I;
        end
      end
      S_LOAD_I: begin
        i_ready = w_i_rdy;
        if (i_valid && w_i_rdy) begin
          w_i_hs       = 1'b1;
          pe_ifmap     = i_data;
          pe_ifmap_wen = 1'b1;
          if (w_last_pix) w_state_nxt = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (!r_cap_pend && o_valid && o_ready) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register, row-length latch, weight/pixel counters and capture flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_row_len  <= '0;
      r_pix_cnt  <= '0;
      r_w_cnt    <= '0;
      r_cap_pend <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cap_pend <= w_i_hs && w_window_full;
      if (r_state == S_IDLE && start) r_row_len <= cfg_row_len;
      if (r_state == S_CLEAR) begin
        r_w_cnt   <= '0;
        r_pix_cnt <= '0;
      end
      if (w_w_hs) r_w_cnt <= r_w_cnt + 1'b1;
      if (w_i_hs) r_pix_cnt <= w_pix_inc;
    end
  end

  pe_row_out_slot #(
    .PSUM_WID (PSUM_WID)
  ) u_out_slot (
    .clk     (clk),
    .rst_n   (rst),
    .i_load  (r_cap_pend),
    .i_last  (w_cap_last),
    .i_psum  (pe_psum),
    .i_ready (o_ready),
    .o_valid (o_valid),
    .o_last  (o_last),
    .o_psum  (o_psum)
  );

endmodule

// File: tb/tb_pe_row_seq.sv
// Scoreboard bench for pe_row_seq with a behavioural PE attached to its load
// ports. Expected partial sums come from the row's weights and pixels.
module tb_pe_row_seq;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               start = 1'b0;
  logic [7:0]         cfg_row_len = '0;
  logic               busy, done;
  logic               w_valid = 1'b0;
  logic               w_ready;
  logic signed [7:0]  w_data = '0;
  logic               i_valid = 1'b0;
  logic               i_ready;
  logic signed [7:0]  i_data = '0;
  logic signed [7:0]  pe_ifmap;
  logic               pe_ifmap_wen;
  logic signed [7:0]  pe_weight;
  logic               pe_weight_wen;
  logic               pe_reg_clear;
  logic signed [19:0] pe_psum;
  logic               o_valid;
  logic               o_ready = 1'b1;
  logic signed [19:0] o_psum;
  logic               o_last;

  pe_row_seq dut (
    .clk (clk), .rst (rst), .start (start), .cfg_row_len (cfg_row_len),
    .busy (busy), .done (done),
    .w_valid (w_valid), .w_ready (w_ready), .w_data (w_data),
    .i_valid (i_valid), .i_ready (i_ready), .i_data (i_data),
    .pe_ifmap (pe_ifmap), .pe_ifmap_wen (pe_ifmap_wen),
    .pe_weight (pe_weight), .pe_weight_wen (pe_weight_wen),
    .pe_reg_clear (pe_reg_clear), .pe_psum (pe_psum),
    .o_valid (o_valid), .o_ready (o_ready), .o_psum (o_psum), .o_last (o_last)
  );

  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void chk(input string nm, input longint act, input longint req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", nm, act, req);
    end
  endfunction

  // Behavioural PE: weight FIFO, 3-deep ifmap shift window, combinational dot product
  logic signed [7:0] pe_w [3];
  logic signed [7:0] pe_x [3];
  int                pe_wn = 0;
  int                pe_sum;

  always @(posedge clk) begin
    if (pe_reg_clear) begin
      pe_wn <= 0;
      for (int k = 0; k < 3; k++) begin
        pe_w[k] <= '0;
        pe_x[k] <= '0;
      end
    end else begin
      if (pe_weight_wen && pe_wn < 3) begin
        pe_w[pe_wn] <= pe_weight;
        pe_wn <= pe_wn + 1;
      end
      if (pe_ifmap_wen) begin
        pe_x[0] <= pe_x[1];
        pe_x[1] <= pe_x[2];
        pe_x[2] <= pe_ifmap;
      end
    end
  end

  always_comb begin
    pe_sum = 0;
    for (int k = 0; k < 3; k++) pe_sum = pe_sum + int'(pe_w[k]) * int'(pe_x[k]);
    pe_psum = pe_sum[19:0];
  end

  typedef struct {
    logic signed [19:0] psum;
    logic               last;
  } exp_t;
  exp_t exp_q[$];

  // Monitor: pops on every output handshake, checks hold/backpressure and load strobes
  logic               hold_v = 1'b0;
  logic signed [19:0] hold_psum;
  logic               hold_last;
  always @(negedge clk) begin
    if (!rst) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        chk("hold_valid", o_valid, 1);
        chk("hold_psum", o_psum, hold_psum);
        chk("hold_last", o_last, hold_last);
      end
      if (o_valid && !o_ready) chk("stall_i_ready", i_ready, 0);
      if (o_valid && o_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("out_psum", o_psum, e.psum);
          chk("out_last", o_last, e.last);
        end
      end
      if (pe_ifmap_wen) begin
        chk("ifmap_wen_hs", i_valid && i_ready, 1);
        chk("ifmap_data", pe_ifmap, i_data);
      end
      if (pe_weight_wen) begin
        chk("weight_wen_hs", w_valid && w_ready, 1);
        chk("weight_data", pe_weight, w_data);
      end
      hold_v    = o_valid && !o_ready;
      hold_psum = o_psum;
      hold_last = o_last;
    end
  end

  function automatic longint all_outs();
    return longint'({busy, done, w_ready, i_ready, pe_ifmap, pe_ifmap_wen, pe_weight,
                     pe_weight_wen, pe_reg_clear, o_valid, o_psum, o_last});
  endfunction

  // One row: push expected outputs, start, feed streams, watch for done.
  // stall_at: after that many pixels, hold o_ready low for 12 cycles.
  // abort_at: after that many pixels and with o_valid high, assert reset.
  task automatic run_row(input int len, input int ws[3], input int px[$], input bit rnd,
                         input int stall_at, input int abort_at);
    int wi = 0, pi = 0, cyc = 0, done_n = 0, stall_left = 0;
    bit fin = 0, aborted = 0, saw_rdy = 0;
    for (int n = 2; n < len; n++) begin
      int   e;
      exp_t x;
      e = ws[0] * px[n-2] + ws[1] * px[n-1] + ws[2] * px[n];
`ifdef PE_ROW_SEQ_RELU_EN
      if (e < 0) e = 0;
`endif
      x.psum = e[19:0];
      x.last = (n == len - 1);
      exp_q.push_back(x);
    end
    @(posedge clk); #1;
    start = 1'b1;
    cfg_row_len = len[7:0];
    @(posedge clk); #1;
    while (!fin) begin
      start       = rnd ? ($urandom_range(0, 7) == 0) : 1'b0;
      cfg_row_len = 8'($urandom);
      w_valid = (wi < 3) && (!rnd || $urandom_range(0, 2) != 0);
      w_data  = (wi < 3) ? 8'(ws[wi]) : 8'($urandom);
      i_valid = (pi < px.size() || len < 3) && (!rnd || $urandom_range(0, 2) != 0);
      i_data  = (pi < px.size()) ? 8'(px[pi]) : 8'($urandom);
      if (stall_left > 0) begin
        o_ready = 1'b0;
        stall_left--;
      end else begin
        o_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      @(negedge clk);
      if (cyc == 0) begin
        chk("clear_pulse", pe_reg_clear, 1);
        chk("busy_in_row", busy, 1);
      end
      if (cyc == 1) begin
        if (len >= 3) chk("w_ready_latency", w_ready, 1);
        else chk("short_done_latency", done, 1);
      end
      if (w_ready || i_ready) saw_rdy = 1;
      if (w_valid && w_ready) wi++;
      if (i_valid && i_ready) begin
        pi++;
        if (pi == stall_at) stall_left = 12;
      end
      if (done) begin
        done_n++;
        fin = 1;
      end
      if (abort_at > 0 && pi >= abort_at && o_valid) begin
        rst = 1'b0;
        #1;
        chk("reset_outputs_zero", all_outs(), 0);
        exp_q.delete();
        aborted = 1;
        fin = 1;
      end
      cyc++;
      if (cyc > 2000 && !fin) begin
        chk("row_timeout", cyc, 2000);
        fin = 1;
        aborted = 1;
      end
      if (!fin) begin
        @(posedge clk); #1;
      end
    end
    start = 1'b0; w_valid = 1'b0; i_valid = 1'b0; o_ready = 1'b1;
    if (!aborted) begin
      chk("done_pulses", done_n, 1);
      chk("weights_taken", wi, (len >= 3) ? 3 : 0);
      chk("pixels_taken", pi, (len >= 3) ? len : 0);
      chk("outputs_left", exp_q.size(), 0);
      if (len < 3) chk("short_no_ready", saw_rdy, 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("idle_after_done", {busy, done}, 0);
    end
  endtask

  initial begin
    int ws[3];
    int px[$];

    @(negedge clk);
    chk("reset_outputs", all_outs(), 0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Basic row: 14, 20, 26
    ws = '{1, 2, 3};
    px = {1, 2, 3, 4, 5};
    run_row(5, ws, px, 0, 0, 0);

    // Minimum row: single output 14 flagged last
    ws = '{2, 0, 0};
    px = {7, 1, 1};
    run_row(3, ws, px, 0, 0, 0);

    // Short rows: clear then done, nothing consumed
    px = {};
    run_row(2, ws, px, 0, 0, 0);
    run_row(0, ws, px, 0, 0, 0);

    // Backpressure on the basic row
    ws = '{1, 2, 3};
    px = {1, 2, 3, 4, 5};
    run_row(5, ws, px, 0, 3, 0);

    // Negative sum: -5, or 0 with the clamp built in
    ws = '{-1, 0, 0};
    px = {5, 1, 1};
    run_row(3, ws, px, 0, 0, 0);

    // Reset mid-row, then the basic row again
    ws = '{1, 2, 3};
    px = {1, 2, 3, 4, 5};
    run_row(5, ws, px, 0, 0, 4);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    run_row(5, ws, px, 0, 0, 0);

    // Randomized rows with stream gaps, random backpressure and stray starts
    for (int r = 0; r < 10; r++) begin
      int len;
      len = (r == 9) ? 1 : int'($urandom_range(3, 12));
      for (int k = 0; k < 3; k++) ws[k] = int'($urandom_range(0, 255)) - 128;
      px = {};
      if (len >= 3)
        for (int k = 0; k < len; k++) px.push_back(int'($urandom_range(0, 255)) - 128);
      run_row(len, ws, px, 1, 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
